// File: rtl/nn_param_loader_if.sv
// Parameter-loader bus: serial word/command inputs and the active bank, status and readback outputs.
interface nn_param_loader_if #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 4
);
  localparam int TOTAL = N_NEURONS * (N_INPUTS + 1);
  localparam int CW    = $clog2(TOTAL + 1);

  logic [WIDTH-1:0]       data_in;
  logic                   data_valid;
  logic [1:0]             cmd;
  logic [TOTAL*WIDTH-1:0] params;
  logic                   params_valid;
  logic                   shadow_full;
  logic [CW-1:0]          word_count;
  logic                   commit_err;
  logic [WIDTH-1:0]       data_out;

  modport master (
    output data_in, data_valid, cmd,
    input  params, params_valid, shadow_full, word_count, commit_err, data_out
  );

  modport slave (
    input  data_in, data_valid, cmd,
    output params, params_valid, shadow_full, word_count, commit_err, data_out
  );
endinterface

// File: rtl/nn_param_loader.sv
// Double-buffered NN parameter loader: words shift into a shadow chain, COMMIT copies it to the active bank one edge later;
// no backpressure, one accept per clock. NN_PARAM_READBACK_EN adds a registered serial readback on data_out.
module nn_param_loader #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 4
) (
  input logic              clk,
  input logic              reset,
  nn_param_loader_if.slave bus
);
  localparam int TOTAL = N_NEURONS * (N_INPUTS + 1);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int BITS  = TOTAL * WIDTH;

  localparam logic [1:0] CMD_LOAD   = 2'b01;
  localparam logic [1:0] CMD_COMMIT = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [CW-1:0] FULL_COUNT = CW'(TOTAL);

  // Shadow index 0 lives in the low word; new words enter at the top.
  logic [BITS-1:0] r_shadow;
  logic [BITS-1:0] r_params;
  logic [CW-1:0]   r_word_count;
  logic            r_shadow_full;
  logic            r_params_valid;
  logic            r_commit_err;

  logic            w_accept;
  logic            w_commit;
  logic            w_clear;
  logic [CW-1:0]   w_count_inc;

  assign w_accept    = (bus.cmd == CMD_LOAD) && bus.data_valid;
  assign w_commit    = (bus.cmd == CMD_COMMIT);
  assign w_clear     = (bus.cmd == CMD_CLEAR);
  assign w_count_inc = r_shadow_full ? r_word_count : r_word_count + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow       <= '0;
      r_params       <= '0;
      r_word_count   <= '0;
      r_shadow_full  <= 1'b0;
      r_params_valid <= 1'b0;
      r_commit_err   <= 1'b0;
    end else if (w_accept) begin
      r_shadow      <= {bus.data_in, r_shadow[BITS-1:WIDTH]};
      r_word_count  <= w_count_inc;
      r_shadow_full <= (w_count_inc == FULL_COUNT);
    end else if (w_clear) begin
      r_shadow      <= '0;
      r_word_count  <= '0;
      r_shadow_full <= 1'b0;
      r_commit_err  <= 1'b0;
    end else if (w_commit) begin
      // A partial set never reaches the datapath; the attempt is flagged instead.
      if (r_shadow_full) begin
        r_params       <= r_shadow;
        r_params_valid <= 1'b1;
        r_word_count   <= '0;
        r_shadow_full  <= 1'b0;
      end else begin
        r_commit_err <= 1'b1;
      end
    end
  end

  assign bus.params       = r_params;
  assign bus.params_valid = r_params_valid;
  assign bus.shadow_full  = r_shadow_full;
  assign bus.word_count   = r_word_count;
  assign bus.commit_err   = r_commit_err;

`ifdef NN_PARAM_READBACK_EN
  logic [WIDTH-1:0] r_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (w_accept) begin
      r_data_out <= r_shadow[WIDTH-1:0];
    end
  end

  assign bus.data_out = r_data_out;
`else
  assign bus.data_out = '0;
`endif
endmodule

// File: tb/tb_nn_param_loader.sv
// Self-checking bench for nn_param_loader: table vectors, a scoreboard-fed reference model and a reparameterised instance.
module tb_nn_param_loader;
  localparam int W     = 8;
  localparam int NN    = 4;
  localparam int NI    = 4;
  localparam int TOTAL = NN * (NI + 1);
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] LOAD   = 2'b01;
  localparam logic [1:0] COMMIT = 2'b10;
  localparam logic [1:0] CLEAR  = 2'b11;

`ifdef NN_PARAM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic reset2 = 1'b0;
  always #5 clk = ~clk;

  nn_param_loader_if #(.WIDTH(W), .N_NEURONS(NN), .N_INPUTS(NI)) bus ();
  nn_param_loader #(.WIDTH(W), .N_NEURONS(NN), .N_INPUTS(NI)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  nn_param_loader_if #(.WIDTH(12), .N_NEURONS(2), .N_INPUTS(3)) bus2 ();
  nn_param_loader #(.WIDTH(12), .N_NEURONS(2), .N_INPUTS(3)) dut2 (
    .clk  (clk),
    .reset(reset2),
    .bus  (bus2)
  );

  typedef struct {
    logic [TOTAL*W-1:0] params;
    logic               valid;
    logic               full;
    logic [CW-1:0]      count;
    logic               err;
    logic [W-1:0]       dout;
  } exp_t;

  typedef struct {
    logic [1:0]   cmd;
    logic         dv;
    logic [W-1:0] din;
    int           exp_count;
    logic         exp_full;
    logic         exp_valid;
    logic         exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[21];

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0]       m_sh[TOTAL];
  logic [TOTAL*W-1:0] m_params;
  int                 m_count;
  logic               m_valid;
  logic               m_err;
  logic [W-1:0]       m_dout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_p(input string name, input logic [TOTAL*W-1:0] act,
                         input logic [TOTAL*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour, written as an explicit word array rather than a packed shift.
  function automatic void model(input logic rst, input logic [1:0] c, input logic dv,
                                input logic [W-1:0] d);
    if (rst) begin
      for (int i = 0; i < TOTAL; i++) m_sh[i] = '0;
      m_params = '0;
      m_count  = 0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_dout   = '0;
    end else if (c == LOAD && dv) begin
      if (RB) m_dout = m_sh[0];
      for (int i = 0; i < TOTAL - 1; i++) m_sh[i] = m_sh[i+1];
      m_sh[TOTAL-1] = d;
      if (m_count < TOTAL) m_count++;
    end else if (c == CLEAR) begin
      for (int i = 0; i < TOTAL; i++) m_sh[i] = '0;
      m_count = 0;
      m_err   = 1'b0;
    end else if (c == COMMIT) begin
      if (m_count == TOTAL) begin
        for (int i = 0; i < TOTAL; i++) m_params[i*W +: W] = m_sh[i];
        m_valid = 1'b1;
        m_count = 0;
      end else begin
        m_err = 1'b1;
      end
    end
  endfunction

  task automatic step(input logic rst, input logic [1:0] c, input logic dv, input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.cmd        = c;
    bus.data_valid = dv;
    bus.data_in    = d;
    model(rst, c, dv, d);
    e.params = m_params;
    e.valid  = m_valid;
    e.full   = (m_count == TOTAL);
    e.count  = CW'(m_count);
    e.err    = m_err;
    e.dout   = m_dout;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;
    e = sb.pop_front();
    check_p("sb_params", bus.params, e.params);
    check("sb_valid", 64'(bus.params_valid), 64'(e.valid));
    check("sb_full", 64'(bus.shadow_full), 64'(e.full));
    check("sb_count", 64'(bus.word_count), 64'(e.count));
    check("sb_err", 64'(bus.commit_err), 64'(e.err));
    check("sb_dout", 64'(bus.data_out), 64'(e.dout));
  endtask

  initial begin
    bus.cmd         = HOLD;
    bus.data_valid  = 1'b0;
    bus.data_in     = '0;
    bus2.cmd        = HOLD;
    bus2.data_valid = 1'b0;
    bus2.data_in    = '0;

    for (int i = 0; i < 20; i++)
      tbl[i] = '{LOAD, 1'b1, 8'(i + 1), i + 1, (i == 19), 1'b0, 1'b0};
    tbl[20] = '{COMMIT, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0};

    // Reset state
    step(1'b1, HOLD, 1'b0, '0);
    check_p("reset_params", bus.params, '0);
    check("reset_count", 64'(bus.word_count), 64'd0);

    // Full load 1..20 and commit, table-driven
    for (int i = 0; i < 21; i++) begin
      step(1'b0, tbl[i].cmd, tbl[i].dv, tbl[i].din);
      check("tbl_count", 64'(bus.word_count), 64'(tbl[i].exp_count));
      check("tbl_full", 64'(bus.shadow_full), 64'(tbl[i].exp_full));
      check("tbl_valid", 64'(bus.params_valid), 64'(tbl[i].exp_valid));
      check("tbl_err", 64'(bus.commit_err), 64'(tbl[i].exp_err));
    end
    check("word0", 64'(bus.params[0*W +: W]), 64'd1);
    check("word4_b0", 64'(bus.params[4*W +: W]), 64'd5);
    check("word19_b3", 64'(bus.params[19*W +: W]), 64'd20);

    // Early commit is rejected, CLEAR wipes the error
    step(1'b1, HOLD, 1'b0, '0);
    for (int i = 0; i < 7; i++) step(1'b0, LOAD, 1'b1, 8'(8'h30 + i));
    step(1'b0, COMMIT, 1'b0, '0);
    check("early_err", 64'(bus.commit_err), 64'd1);
    check("early_valid", 64'(bus.params_valid), 64'd0);
    check_p("early_params", bus.params, '0);
    check("early_count", 64'(bus.word_count), 64'd7);
    step(1'b0, CLEAR, 1'b1, 8'hFF);
    check("clear_err", 64'(bus.commit_err), 64'd0);
    check("clear_count", 64'(bus.word_count), 64'd0);

    // Active bank stays put during a reload
    for (int i = 0; i < TOTAL; i++) step(1'b0, LOAD, 1'b1, 8'hAA);
    step(1'b0, COMMIT, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, LOAD, 1'b1, 8'h55);
      check_p("hold_A", bus.params, {TOTAL{8'hAA}});
    end
    for (int i = 0; i < 10; i++) step(1'b0, LOAD, 1'b1, 8'h55);
    check_p("still_A", bus.params, {TOTAL{8'hAA}});
    step(1'b0, COMMIT, 1'b0, '0);
    check_p("now_55", bus.params, {TOTAL{8'h55}});

    // Overflow word shifts the oldest word out
    step(1'b1, HOLD, 1'b0, '0);
    for (int i = 0; i < TOTAL; i++) step(1'b0, LOAD, 1'b1, 8'(i + 1));
    step(1'b0, LOAD, 1'b1, 8'h99);
    check("ovf_count", 64'(bus.word_count), 64'd20);
    check("ovf_full", 64'(bus.shadow_full), 64'd1);
    check("ovf_dout", 64'(bus.data_out), RB ? 64'd1 : 64'd0);
    step(1'b0, COMMIT, 1'b0, '0);
    check("ovf_word0", 64'(bus.params[0*W +: W]), 64'd2);
    check("ovf_word19", 64'(bus.params[19*W +: W]), 64'h99);

    // data_valid gating and HOLD
    step(1'b0, CLEAR, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, LOAD, 1'(i % 2), 8'(8'h40 + i));
    check("toggle_count", 64'(bus.word_count), 64'd4);
    step(1'b0, HOLD, 1'b1, 8'h77);
    check("hold_count", 64'(bus.word_count), 64'd4);
    step(1'b0, COMMIT, 1'b1, 8'h77);
    check("commit_dv_ignored", 64'(bus.word_count), 64'd4);

    // Reset in the middle of a load after a prior commit
    for (int i = 0; i < TOTAL; i++) step(1'b0, LOAD, 1'b1, 8'(8'hC0 + i));
    step(1'b0, COMMIT, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, LOAD, 1'b1, 8'h11);
    step(1'b1, LOAD, 1'b1, 8'h22);
    check_p("rst_params", bus.params, '0);
    check("rst_valid", 64'(bus.params_valid), 64'd0);
    check("rst_count", 64'(bus.word_count), 64'd0);
    check("rst_err", 64'(bus.commit_err), 64'd0);
    check("rst_dout", 64'(bus.data_out), 64'd0);

    // Reparameterised instance: 2 neurons x 3 inputs, 12-bit words
    @(negedge clk);
    reset2 = 1'b1;
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    check("p2_reset_full", 64'(bus2.shadow_full), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus2.cmd        = LOAD;
      bus2.data_valid = 1'b1;
      bus2.data_in    = 12'(12'h100 + i);
      @(posedge clk);
      #1;
      check("p2_count", 64'(bus2.word_count), 64'(i + 1));
      check("p2_full", 64'(bus2.shadow_full), (i == 7) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    bus2.cmd        = COMMIT;
    bus2.data_valid = 1'b0;
    @(posedge clk);
    #1;
    check("p2_word3", 64'(bus2.params[3*12 +: 12]), 64'h103);
    check("p2_word7", 64'(bus2.params[7*12 +: 12]), 64'h107);
    check("p2_valid", 64'(bus2.params_valid), 64'd1);
    @(negedge clk);
    bus2.cmd = HOLD;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
